// File: rtl/multi_scale_seq.sv
// multi_scale_seq: captures one DW-bit sample over a valid/ready handshake,
// then presents it multiplied by each of N constant coefficients on N
// consecutive output beats. The beats obey downstream backpressure.
// Back-to-back samples run with no bubble. Continuous mode replays the held sample.
module multi_scale_seq #(
    parameter int                DW   = 8,
    parameter int                N    = 4,
    parameter int                CW   = 4,
    parameter logic [N*CW-1:0]   COEF = 16'h8731,
    localparam int               OW   = DW + CW,
    localparam int               IW   = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          cont,
    input  logic          out_ready,
    output logic [OW-1:0] out,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          input_grant
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] d_reg, d_reg_d;
    logic [OW-1:0] out_d;
    logic [IW-1:0] idx_d;
    logic          grant_d;
    logic          accept;

    // Sample times coefficient 'sel'. The coefficient is a constant, so this reduces to shift-add.
    function automatic logic [OW-1:0] scale(input logic [DW-1:0] s,
                                            input logic [IW-1:0] sel);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == IW'(k)) c = COEF[k*CW +: CW];
        end
        return OW'(s) * OW'(c);
    endfunction

    // The beat is valid whenever a sequence is running. The last-beat flag is decoded from the registered index.
    assign out_valid = (state_q == RUN);
    assign out_last  = out_valid & (out_idx == LAST_IDX);
    assign in_ready  = !out_valid | (out_last & out_ready);
    assign accept    = in_valid & in_ready;

    // Next-state decode: accept wins, then advance, then continuous replay, then idle.
    always_comb begin
        // NOTE: every output of this block gets a hold default first so no path infers a latch.
        state_d = state_q;
        d_reg_d = d_reg;
        out_d   = out;
        idx_d   = out_idx;
        grant_d = input_grant;
        if (accept) begin
            state_d = RUN;
            d_reg_d = d;
            idx_d   = '0;
            out_d   = scale(d, '0);
            grant_d = 1'b1;
        end else if (out_valid && out_ready) begin
            grant_d = 1'b0;
            if (!out_last) begin
                idx_d = out_idx + IW'(1);
                out_d = scale(d_reg, out_idx + IW'(1));
            end else if (cont) begin
                idx_d = '0;
                out_d = scale(d_reg, '0);
            end else begin
                state_d = IDLE;
                idx_d   = '0;
                out_d   = '0;
            end
        end
    end

    // State and output registers. The asynchronous reset discards any in-flight sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            d_reg       <= '0;
            out         <= '0;
            out_idx     <= '0;
            input_grant <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every register see pre-edge values, independent of statement order.
            state_q     <= state_d;
            d_reg       <= d_reg_d;
            out         <= out_d;
            out_idx     <= idx_d;
            input_grant <= grant_d;
        end
    end

endmodule

// File: doc/multi_scale_seq.md
# multi_scale_seq

Parametrised sequential constant-scaler, the next generation of the team's multi-select block. It accepts one DW-bit sample through a valid/ready handshake. It then presents the sample multiplied by each of N compile-time coefficients on N consecutive output beats. Beats obey downstream backpressure, back-to-back samples run with no bubble, and an optional continuous mode replays the held sample. It sits between a sample source and a datapath that consumes fixed-ratio scaled copies.

## Interface
- DW, 8: input sample width.
- N, 4: coefficient count, legal range 2..16.
- CW, 4: width of each coefficient.
- COEF, 16'h8731: packed coefficients. Entry k is COEF[k*CW +: CW]. The default gives 1, 3, 7, 8 for k = 0..3.
- Derived: OW = DW+CW; IW = max(1, clog2(N)).

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- d  in  DW  input sample, unsigned.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample this cycle. Combinational.
- cont  in  1  continuous mode. Sampled only at the end of a sequence.
- out_ready  in  1  downstream accepts the current beat.
- out  out  OW  d_reg*COEF[out_idx], unsigned.
- out_valid  out  1  out is a valid beat.
- out_idx  out  IW  coefficient index of the current beat.
- out_last  out  1  current beat is index N-1.
- input_grant  out  1  high on the first beat (idx 0) of a sequence started by a newly captured sample.

## Operation
- Internal state: d_reg (DW bits), plus IDLE/RUN. RUN is equivalent to out_valid=1.
- All outputs except in_ready are registered.
- in_ready = !out_valid | (out_last & out_ready).
- A sample is accepted when in_valid & in_ready is high at a rising edge.
- **Accept:** d_reg<=d, out_valid<=1, out_idx<=0, out<=d*COEF[0], input_grant<=1.
- **Advance** (out_valid & out_ready & !out_last): out_idx<=out_idx+1, out<=d_reg*COEF[out_idx+1], input_grant<=0.
- **Stall** (out_valid & !out_ready): all registered outputs and d_reg hold.
- **End of sequence** (out_valid & out_last & out_ready). Priority: accept first, then cont, then idle.
  - in_valid=1: accept the new sample, giving back-to-back operation with no bubble.
  - else cont=1: out_idx<=0, out<=d_reg*COEF[0], input_grant<=0, d_reg held.
  - else: out_valid<=0, out_idx<=0, out<=0, input_grant<=0.
- out_last = out_valid & (out_idx==N-1). It may be decoded combinationally from registered state.
- Arithmetic:
  - Products use the full OW bits. No truncation or overflow is possible.
  - Multiplication is by constant, so synthesis may use shift-add. No DSP multiplier is required.
  - A coefficient of 0 produces an out=0 beat, still valid.
- in_valid while in RUN and not at an end-of-sequence handshake is ignored. d is not sampled.
- d, cont and out_ready may change every cycle. Only their values at the relevant edge matter.

## Timing
- Reset, applied asynchronously at any point, including mid-sequence:
  - out=0, out_valid=0, out_idx=0, input_grant=0, d_reg=0.
  - in_ready reads 1 immediately.
  - The in-flight sequence is discarded. The first post-reset accept starts at idx 0.
- Latency: a sample accepted at edge T appears as beat 0 after edge T.
- With out_ready held high, beat k appears after edge T+k. The last beat appears after edge T+N-1.
- Throughput: one sample per N cycles with out_ready high and in_valid continuously high.
- input_grant is high for exactly one cycle per accepted sample, aligned with that sample's idx-0 beat. It stays high across a stall on beat 0.
- Simultaneous end of sequence with in_valid and cont: the new sample wins and input_grant=1.
- out_ready low on the last beat keeps in_ready low. The offered sample waits, with no loss and no duplicate.

## Test plan
- **Basic sequence.** Defaults, d=10, single in_valid pulse, out_ready=1.
  - Beats out=10, 30, 70, 80, with idx 0..3.
  - input_grant only with 10; out_last only with 80.
  - Then out_valid=0 and out=0.
- **Back-to-back.** d=255 then d=1, in_valid held, out_ready=1.
  - Beats 255, 765, 1785, 2040, 1, 3, 7, 8 with no gap.
  - in_ready high only on the idx-3 cycles and while idle.
  - input_grant on 255 and on 1.
- **Backpressure.** d=10, out_ready=0 for 3 cycles while idx=1.
  - out=30 and idx=1 hold for 4 cycles, then the sequence continues 70, 80.
  - in_valid during the stall is not accepted.
- **Continuous mode.** d=10 accepted, then cont=1 and in_valid=0.
  - 10, 30, 70, 80 repeats indefinitely with input_grant=0 on every repeat.
  - Asserting in_valid with d=2 at an idx-3 handshake yields 2, 6, 14, 16 with input_grant=1.
- **Reset mid-run.** rst low asynchronously at idx=2 of d=10.
  - All outputs are 0 at once and in_ready=1.
  - After release, d=5 gives 5, 15, 35, 40.
- **Parameter variant.** N=3, CW=4, COEF=12'h521, d=7.
  - Beats 7, 14, 35, idx 0..2, out_last on 35.
  - OW=12; d=255 gives 255, 510, 1275.
